pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program-counter and instruction-fetch stage directly upstream of the control decoder.
//  - Owns the PC register and fetches each instruction over the shared memory bus.
//  - Holds the fetched word in an instruction register; bits [6:0] feed opCode and [14:12] feed funct.
//  - Computes the next PC from the decoder's BranchEQ/BranchNE/JalFunct/PCMux outputs and the ALU zero flag.
// PARAMETERS
//  XLEN      32            datapath/PC width
//  RESET_PC  32'h0040_0000 PC value loaded on reset
// PORTS
//  clk           in   1     system clock, rising edge
//  rst           in   1     synchronous, active-high reset
//  instr_req     out  1     fetch request to memory (bus owned by fetch while high)
//  instr_rdata   in   XLEN  instruction word from memory
//  instr_ready   in   1     instr_rdata valid this cycle
//  ex_stall      in   1     hold current instruction in EXEC (data access/UART busy)
//  BranchEQ      in   1     decoder: beq
//  BranchNE      in   1     decoder: bne
//  JalFunct      in   1     decoder: jal
//  PCMux         in   1     decoder: jalr
//  zero          in   1     ALU result == 0
//  imm           in   XLEN  sign-extended immediate from the immediate generator
//  rs1_data      in   XLEN  register-file RD1 (jalr base)
//  pc            out  XLEN  current PC (ALUSrcA=0 operand)
//  pc_plus4      out  XLEN  pc + 4
//  instr         out  XLEN  instruction register
//  exec_en       out  1     instruction valid; qualifies RegWrite/MemWrite
//  misalign_err  out  1     sticky: computed target not 4-byte aligned
// BEHAVIOUR
//  - Reset (rst=1 at posedge, any state): pc=RESET_PC, instr=32'h0000_0013 (nop), state=FETCH,
//    exec_en=0, instr_req=0, misalign_err=0. Overrides any in-flight fetch.
//  - FSM FETCH -> EXEC -> FETCH; HALT is terminal until reset.
//  - FETCH: instr_req=1.
//    - instr_ready=1: instr<=instr_rdata, go EXEC. Fetch latency is 1 cycle minimum.
//    - instr_ready=0: stay in FETCH; pc and instr hold.
//  - EXEC: exec_en=1, instr_req=0.
//    - ex_stall=1: stay in EXEC; pc and instr hold.
//    - ex_stall=0: pc<=next_pc, go FETCH.
//  - next_pc priority:
//    1. PCMux:                          (rs1_data+imm) & ~1
//    2. JalFunct:                       pc+imm
//    3. (BranchEQ&zero)|(BranchNE&~zero): pc+imm
//    4. otherwise:                      pc_plus4
//  - All adds are XLEN-bit modulo; 32'hFFFF_FFFC+4 wraps to 0 with no flag.
//  - If next_pc[1]=1 at the EXEC commit: pc holds, misalign_err<=1, go HALT.
//  - HALT: exec_en=0, instr_req=0; exited only by rst.
//  - Decoder inputs are sampled only in EXEC; they are don't-care in FETCH and HALT.
//  - Simultaneous instr_ready in the reset cycle is ignored.
// CONFIGURATION
//  RETIRE_COUNT_EN defined:
//   - Adds output instret[63:0], reset 0.
//   - Increments once per EXEC->FETCH transition.
//   - Does not increment on stall cycles or on the misaligned commit.
//  RETIRE_COUNT_EN undefined: no counter and no port.
// STRUCTURE
//  - Shared package riscv_pkg:
//    - opcode localparams (R/I/S/B/JAL/JALR/AUIPC/LW)
//    - NOP_INSTR = 32'h0000_0013
//    - fetch FSM state encoding: FETCH=2'd0, EXEC=2'd1, HALT=2'd2
//  - Sub-module next_pc_sel: purely combinational target mux and misalign check.
//  - pc_fetch_unit keeps the FSM, PC, IR and counter.
// TESTING
//  1. Reset, then instr_ready=1 every fetch, no branch:
//     pc = 0x00400000, 0x00400004, 0x00400008, with exec_en high every 2nd cycle.
//  2. instr_ready held low 3 cycles: instr_req stays 1, pc unchanged, exec_en=0 throughout.
//  3. EXEC with BranchEQ=1, zero=1, imm=-8 at pc=0x00400010: next pc = 0x00400008.
//     Same with zero=0: next pc = 0x00400014.
//  4. PCMux=1, rs1=0x00400101, imm=3, plus JalFunct=1 simultaneously:
//     pc = 0x00400104 (jalr wins, bit0 cleared).
//  5. JalFunct=1 with imm=6: misalign_err=1, FSM enters HALT, pc holds.
//     rst then recovers to RESET_PC.
//  6. ex_stall=1 for 2 cycles in EXEC, then rst mid-stall: pc=RESET_PC, exec_en=0 next cycle.
//     With RETIRE_COUNT_EN, instret=0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode slice.
//  - RV32I major opcode values used by the control decoder
//  - NOP_INSTR: canonical nop (addi x0, x0, 0) loaded into the IR on reset
//  - fetchState_t: fetch FSM state encoding
package riscv_pkg;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_S     = 7'b0100011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_LW    = 7'b0000011;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      EXEC  = 2'd1,
      HALT  = 2'd2
   } fetchState_t;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection and alignment check.
// Ports:
//  pc, pcPlus4       current PC and its sequential successor
//  rs1Data, imm      jalr base and sign-extended immediate
//  BranchEQ/BranchNE/JalFunct/PCMux/zero   decoder controls and ALU zero flag
//  nextPc            selected target (jalr > jal > taken branch > pc+4)
//  misaligned        nextPc[1] set; bit 0 is cleared for jalr and ignored otherwise
module next_pc_sel #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] pcPlus4,
   input  logic [XLEN-1:0] rs1Data,
   input  logic [XLEN-1:0] imm,
   input  logic            BranchEQ,
   input  logic            BranchNE,
   input  logic            JalFunct,
   input  logic            PCMux,
   input  logic            zero,
   output logic [XLEN-1:0] nextPc,
   output logic            misaligned
);
   import riscv_pkg::*;

   logic [XLEN-1:0] jalrTarget;
   logic [XLEN-1:0] relTarget;
   logic            branchTaken;

   assign jalrTarget  = (rs1Data + imm) & ~XLEN'(1);
   assign relTarget   = pc + imm;
   assign branchTaken = (BranchEQ & zero) | (BranchNE & ~zero);

   always_comb begin
      nextPc = pcPlus4;
      if (PCMux)
         nextPc = jalrTarget;
      else if (JalFunct || branchTaken)
         nextPc = relTarget;
   end

   assign misaligned = nextPc[1];

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch stage feeding the control decoder.
// Owns the PC and the instruction register and runs the fetch/execute handshake
// on the shared memory bus.
// Ports:
//  clk, rst          clock, synchronous active-high reset
//  instr_req         fetch request (bus owned by fetch while high)
//  instr_rdata/ready instruction word from memory and its valid strobe
//  ex_stall          hold the current instruction in EXEC
//  BranchEQ/BranchNE/JalFunct/PCMux, zero, imm, rs1_data   next-PC inputs
//  pc, pc_plus4, instr, exec_en   fetch outputs to the datapath
//  misalign_err      sticky: a committed target had bit 1 set
//  instret           retired-instruction count (RETIRE_COUNT_EN builds only)
// Build option: define RETIRE_COUNT_EN to add the instret counter and port.
//
// state | meaning
// FETCH | bus request out; waiting for instr_ready to load the IR
// EXEC  | IR valid (exec_en=1); PC commits when ex_stall drops
// HALT  | misaligned target seen; frozen until rst
module pc_fetch_unit
   import riscv_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h0040_0000)
) (
   input  logic            clk,
   input  logic            rst,
   output logic            instr_req,
   input  logic [XLEN-1:0] instr_rdata,
   input  logic            instr_ready,
   input  logic            ex_stall,
   input  logic            BranchEQ,
   input  logic            BranchNE,
   input  logic            JalFunct,
   input  logic            PCMux,
   input  logic            zero,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1_data,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] instr,
   output logic            exec_en,
`ifdef RETIRE_COUNT_EN
   output logic [63:0]     instret,
`endif
   output logic            misalign_err
);

   fetchState_t     state;
   logic [XLEN-1:0] nextPc;
   logic            misaligned;

   assign pc_plus4 = pc + XLEN'(4);

   next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
      .pc         (pc),
      .pcPlus4    (pc_plus4),
      .rs1Data    (rs1_data),
      .imm        (imm),
      .BranchEQ   (BranchEQ),
      .BranchNE   (BranchNE),
      .JalFunct   (JalFunct),
      .PCMux      (PCMux),
      .zero       (zero),
      .nextPc     (nextPc),
      .misaligned (misaligned)
   );

   // instr_req is registered, so the first cycle after reset sits in FETCH with
   // the request still low; a response is only accepted while the request is up.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         instr        <= XLEN'(NOP_INSTR);
         exec_en      <= 1'b0;
         instr_req    <= 1'b0;
         misalign_err <= 1'b0;
`ifdef RETIRE_COUNT_EN
         instret      <= 64'd0;
`endif
      end else begin
         case (state)
            FETCH: begin
               if (instr_req && instr_ready) begin
                  instr     <= instr_rdata;
                  state     <= EXEC;
                  exec_en   <= 1'b1;
                  instr_req <= 1'b0;
               end else begin
                  instr_req <= 1'b1;
               end
            end
            EXEC: begin
               if (!ex_stall) begin
                  exec_en <= 1'b0;
                  if (misaligned) begin
                     misalign_err <= 1'b1;
                     state        <= HALT;
                  end else begin
                     pc        <= nextPc;
                     state     <= FETCH;
                     instr_req <= 1'b1;
`ifdef RETIRE_COUNT_EN
                     instret   <= instret + 64'd1;
`endif
                  end
               end
            end
            HALT: begin
               exec_en   <= 1'b0;
               instr_req <= 1'b0;
            end
            default: begin
               state     <= HALT;
               exec_en   <= 1'b0;
               instr_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;
   import riscv_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0040_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        instr_req;
   logic [31:0] instr_rdata;
   logic        instr_ready;
   logic        ex_stall;
   logic        BranchEQ, BranchNE, JalFunct, PCMux, zero;
   logic [31:0] imm, rs1_data;
   logic [31:0] pc, pc_plus4, instr;
   logic        exec_en;
   logic        misalign_err;
`ifdef RETIRE_COUNT_EN
   logic [63:0] instret;
`endif

   pc_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .instr_req    (instr_req),
      .instr_rdata  (instr_rdata),
      .instr_ready  (instr_ready),
      .ex_stall     (ex_stall),
      .BranchEQ     (BranchEQ),
      .BranchNE     (BranchNE),
      .JalFunct     (JalFunct),
      .PCMux        (PCMux),
      .zero         (zero),
      .imm          (imm),
      .rs1_data     (rs1_data),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .instr        (instr),
      .exec_en      (exec_en),
`ifdef RETIRE_COUNT_EN
      .instret      (instret),
`endif
      .misalign_err (misalign_err)
   );

   always #5 clk = ~clk;

   int nTests = 0;
   int nFail  = 0;
   logic [31:0] expQ[$];

   typedef struct {
      logic        beq, bne, jal, jalr, zf;
      logic [31:0] imm, rs1, word, expPc;
      int          fetchDelay;
   } vec_t;

   vec_t vecs[12];

   function automatic vec_t mk(input logic beq, input logic bne, input logic jal,
                               input logic jalr, input logic zf, input logic [31:0] im,
                               input logic [31:0] r1, input logic [31:0] expPc,
                               input int dly);
      vec_t v;
      v.beq = beq; v.bne = bne; v.jal = jal; v.jalr = jalr; v.zf = zf;
      v.imm = im; v.rs1 = r1; v.expPc = expPc; v.fetchDelay = dly;
      v.word = 32'h0;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic stepClk;
      @(posedge clk);
      #1;
   endtask

   // Decoder inputs are don't-care outside EXEC; drive a jump so a wrong commit shows up.
   task automatic driveDontCare;
      BranchEQ = 1'b1; BranchNE = 1'b1; JalFunct = 1'b1; PCMux = 1'b1; zero = 1'b0;
      imm = 32'h0000_0040; rs1_data = 32'h1234_5678;
   endtask

   task automatic driveVec(input vec_t v);
      BranchEQ = v.beq; BranchNE = v.bne; JalFunct = v.jal; PCMux = v.jalr; zero = v.zf;
      imm = v.imm; rs1_data = v.rs1;
   endtask

   task automatic waitReq;
      int n = 0;
      while (instr_req !== 1'b1 && n < 10) begin
         stepClk;
         n++;
      end
      check("req_wait", 32'(instr_req), 32'd1);
   endtask

   task automatic doReset;
      rst = 1'b1;
      instr_ready = 1'b1;
      instr_rdata = 32'hABCD_0001;
      stepClk;
      rst = 1'b0;
      instr_ready = 1'b0;
      check("rst_pc", pc, RST_PC);
      check("rst_instr", instr, 32'h0000_0013);
      check("rst_exec_en", 32'(exec_en), 32'd0);
      check("rst_req", 32'(instr_req), 32'd0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
   endtask

   // Fetch one word and get into EXEC; returns the PC seen during the fetch.
   task automatic fetchInto(input logic [31:0] word, input int dly, output logic [31:0] pcBefore);
      waitReq;
      pcBefore = pc;
      for (int i = 0; i < dly; i++) begin
         instr_ready = 1'b0;
         stepClk;
         check("fetch_wait_req", 32'(instr_req), 32'd1);
         check("fetch_wait_exec_en", 32'(exec_en), 32'd0);
         check("fetch_wait_pc", pc, pcBefore);
      end
      instr_ready = 1'b1;
      instr_rdata = word;
      stepClk;
      instr_ready = 1'b0;
      instr_rdata = 32'hFFFF_FFFF;
      check("exec_en", 32'(exec_en), 32'd1);
      check("exec_req", 32'(instr_req), 32'd0);
      check("exec_instr", instr, word);
      check("exec_pc", pc, pcBefore);
      check("exec_pc_plus4", pc_plus4, pcBefore + 32'd4);
   endtask

   task automatic runVec(input vec_t v);
      logic [31:0] pcBefore;
      logic [31:0] exp;
      fetchInto(v.word, v.fetchDelay, pcBefore);
      driveVec(v);
      expQ.push_back(v.expPc);
      stepClk;
      driveDontCare;
      check("commit_exec_en", 32'(exec_en), 32'd0);
      check("commit_req", 32'(instr_req), 32'd1);
      exp = expQ.pop_front();
      check("next_pc", pc, exp);
      check("next_pc_plus4", pc_plus4, exp + 32'd4);
      check("commit_misalign", 32'(misalign_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] pcBefore;
      rst = 1'b1;
      instr_ready = 1'b0;
      instr_rdata = 32'h0;
      ex_stall = 1'b0;
      driveDontCare;
      stepClk;
      stepClk;
      doReset;
`ifdef RETIRE_COUNT_EN
      check("instret_reset", instret[31:0], 32'd0);
`endif

      //            beq  bne  jal  jalr zf    imm            rs1            expPc          dly
      vecs[0]  = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0000_0100, 32'h0,         32'h0040_0004, 0);
      vecs[1]  = mk(1'b0,1'b0,1'b0,1'b0,1'b1, 32'h0000_0100, 32'h0,         32'h0040_0008, 3);
      vecs[2]  = mk(1'b0,1'b1,1'b0,1'b0,1'b1, 32'h0000_0100, 32'h0,         32'h0040_000C, 0);
      vecs[3]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 32'h0000_0100, 32'h0,         32'h0040_0010, 1);
      vecs[4]  = mk(1'b1,1'b0,1'b0,1'b0,1'b1, 32'hFFFF_FFF8, 32'h0,         32'h0040_0008, 0);
      vecs[5]  = mk(1'b0,1'b1,1'b0,1'b0,1'b0, 32'h0000_0008, 32'h0,         32'h0040_0010, 0);
      vecs[6]  = mk(1'b1,1'b0,1'b0,1'b0,1'b0, 32'hFFFF_FFF8, 32'h0,         32'h0040_0014, 0);
      vecs[7]  = mk(1'b0,1'b0,1'b1,1'b0,1'b1, 32'h0000_0020, 32'h0,         32'h0040_0034, 0);
      vecs[8]  = mk(1'b0,1'b0,1'b1,1'b1,1'b0, 32'h0000_0003, 32'h0040_0101, 32'h0040_0104, 0);
      vecs[9]  = mk(1'b0,1'b0,1'b0,1'b1,1'b0, 32'h0000_000C, 32'hFFFF_FFF0, 32'hFFFF_FFFC, 0);
      vecs[10] = mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0000_0010, 32'h0,         32'h0000_0000, 2);
      vecs[11] = mk(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0040_0000, 32'h0,         32'h0040_0000, 0);
      for (int i = 0; i < 12; i++)
         vecs[i].word = 32'h0000_0093 | (32'(i + 1) << 20);

      for (int i = 0; i < 12; i++)
         runVec(vecs[i]);
`ifdef RETIRE_COUNT_EN
      check("instret_count", instret[31:0], 32'd12);
`endif

      // Stall in EXEC with a misaligned target pending, then reset mid-stall.
      fetchInto(32'h0050_0093, 0, pcBefore);
      JalFunct = 1'b1; PCMux = 1'b0; BranchEQ = 1'b0; BranchNE = 1'b0;
      imm = 32'h0000_0006;
      ex_stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         stepClk;
         check("stall_exec_en", 32'(exec_en), 32'd1);
         check("stall_pc", pc, pcBefore);
         check("stall_req", 32'(instr_req), 32'd0);
         check("stall_misalign", 32'(misalign_err), 32'd0);
      end
      rst = 1'b1;
      stepClk;
      rst = 1'b0;
      ex_stall = 1'b0;
      driveDontCare;
      check("stall_rst_pc", pc, RST_PC);
      check("stall_rst_exec_en", 32'(exec_en), 32'd0);
      check("stall_rst_req", 32'(instr_req), 32'd0);
`ifdef RETIRE_COUNT_EN
      check("stall_rst_instret", instret[31:0], 32'd0);
`endif

      // Misaligned jal: HALT with pc held, then reset recovers.
      runVec(mk(1'b0,1'b0,1'b1,1'b0,1'b0, 32'h0000_0010, 32'h0, 32'h0040_0010, 0));
      fetchInto(32'h0060_006F, 0, pcBefore);
      BranchEQ = 1'b0; BranchNE = 1'b0; JalFunct = 1'b1; PCMux = 1'b0;
      imm = 32'h0000_0006;
      stepClk;
      check("misalign_err", 32'(misalign_err), 32'd1);
      check("misalign_exec_en", 32'(exec_en), 32'd0);
      check("misalign_req", 32'(instr_req), 32'd0);
      check("misalign_pc", pc, 32'h0040_0010);
      instr_ready = 1'b1;
      driveDontCare;
      for (int i = 0; i < 3; i++) begin
         stepClk;
         check("halt_req", 32'(instr_req), 32'd0);
         check("halt_exec_en", 32'(exec_en), 32'd0);
         check("halt_pc", pc, 32'h0040_0010);
         check("halt_sticky", 32'(misalign_err), 32'd1);
      end
      instr_ready = 1'b0;
      doReset;
      runVec(mk(1'b0,1'b0,1'b0,1'b0,1'b0, 32'h0, 32'h0, 32'h0040_0004, 0));

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule
